// File: rtl/qn_readout_pkg.sv
// Shared definitions for the event-FIFO UART readout path: FSM encoding,
// 8N1 framing constants and a frame builder.
package qn_readout_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VALID = 2'd1,
        SEND_HI    = 2'd2,
        SEND_LO    = 2'd3
    } state_e;

    localparam logic UART_START      = 1'b0;
    localparam logic UART_STOP       = 1'b1;
    localparam int   UART_BITS       = 8;
    localparam int   UART_FRAME_BITS = UART_BITS + 2;
    localparam int   CLK_DIV_115200  = 868;

    // Frame in transmit order from bit 0: start, data LSB..MSB, stop.
    function automatic logic [UART_FRAME_BITS-1:0] uart_frame(input logic [UART_BITS-1:0] data);
        return {UART_STOP, data, UART_START};
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter: a start pulse loads a 10-bit frame that is shifted out
// LSB first, one bit per CLK_DIV cycles; done marks the last stop-bit cycle.
module uart_byte_tx
    import qn_readout_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_115200
) (
    input  logic                 clk100,
    input  logic                 RST_N,
    input  logic                 start_i,
    input  logic [UART_BITS-1:0] byte_i,
    output logic                 txd_o,
    output logic                 done_o
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(UART_FRAME_BITS);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_FRAME_BITS - 1);

    logic [CNT_W-1:0]           baud_q, baud_d;
    logic [BIT_W-1:0]           bit_q, bit_d;
    logic [UART_FRAME_BITS-1:0] shift_q, shift_d;
    logic                       active_q, active_d;

    // A start in the final stop-bit cycle reloads directly, so frames abut.
    always_comb begin
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        active_d = active_q;
        if (start_i) begin
            baud_d   = '0;
            bit_d    = '0;
            shift_d  = uart_frame(byte_i);
            active_d = 1'b1;
        end else if (active_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d  = '0;
                shift_d = {UART_STOP, shift_q[UART_FRAME_BITS-1:1]};
                if (bit_q == BIT_LAST) begin
                    bit_d    = '0;
                    active_d = 1'b0;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    // Shifter resets to all ones so the line idles high.
    always_ff @(posedge clk100 or negedge RST_N) begin
        if (!RST_N) begin
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
            active_q <= 1'b0;
        end else begin
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            active_q <= active_d;
        end
    end

    assign txd_o  = shift_q[0];
    assign done_o = active_q && (baud_q == BAUD_LAST) && (bit_q == BIT_LAST);

endmodule

// File: rtl/fifo_uart_readout.sv
// Readout stage: pops 16-bit event words from the FIFO and sends each as two
// 8N1 UART bytes, high byte first; counts sent words and flags read timeouts.
module fifo_uart_readout
    import qn_readout_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_115200,
    parameter int DATA_W   = 16,
    parameter int VALID_TO = 4
) (
    input  logic              clk100,
    input  logic              RST_N,
    input  logic              FIFO_EMPTY,
    input  logic [DATA_W-1:0] FIFO_DOUT,
    input  logic              FIFO_VALID,
    output logic              FIFO_RD_EN,
    output logic              TXD,
    output logic              BUSY,
    output logic [7:0]        WORD_CNT,
    output logic              ERR,
    output state_e            DBG_STATE
);

    localparam int TO_W = (VALID_TO > 1) ? $clog2(VALID_TO) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(VALID_TO - 1);

    // FIFO read handshake: FIFO_RD_EN is a one-cycle pop request issued only
    // when FIFO_EMPTY is low; the FIFO answers with FIFO_VALID and FIFO_DOUT
    // one cycle later. One pop at most is outstanding; VALID elsewhere is ignored.

    state_e              state_q, state_d;
    logic                rd_en_q, rd_en_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                to_last;
    logic                tx_start;
    logic [UART_BITS-1:0] tx_byte;
    logic                tx_done;
    logic                tx_txd;

    assign to_last = (to_cnt_q == TO_LAST);

    always_ff @(posedge clk100 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IDLE lasts one cycle when a pop is pending: the pop cycle itself.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (rd_en_q) state_d = WAIT_VALID;
            WAIT_VALID: begin
                if (FIFO_VALID) begin
                    state_d = SEND_HI;
                end else if (to_last) begin
                    state_d = IDLE;
                end
            end
            SEND_HI:    if (tx_done) state_d = SEND_LO;
            SEND_LO:    if (tx_done) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // EMPTY is looked at on the edge entering IDLE so the pop lands in the
    // first IDLE cycle, leaving only the pop and wait cycles between words.
    always_comb begin
        rd_en_d  = (state_d == IDLE) && !FIFO_EMPTY;
        busy_d   = (state_d != IDLE);
        word_d   = word_q;
        to_cnt_d = '0;
        cnt_d    = cnt_q;
        err_d    = err_q;
        tx_start = 1'b0;
        tx_byte  = word_q[UART_BITS-1:0];
        case (state_q)
            WAIT_VALID: begin
                tx_byte = FIFO_DOUT[DATA_W-1 -: UART_BITS];
                if (FIFO_VALID) begin
                    word_d   = FIFO_DOUT;
                    tx_start = 1'b1;
                end else if (to_last) begin
                    err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            SEND_HI: begin
                tx_start = tx_done;
            end
            SEND_LO: begin
                if (tx_done) cnt_d = cnt_q + 8'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk100 or negedge RST_N) begin
        if (!RST_N) begin
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            word_q   <= '0;
            to_cnt_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_en_q  <= rd_en_d;
            busy_q   <= busy_d;
            word_q   <= word_d;
            to_cnt_q <= to_cnt_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    uart_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk100  (clk100),
        .RST_N   (RST_N),
        .start_i (tx_start),
        .byte_i  (tx_byte),
        .txd_o   (tx_txd),
        .done_o  (tx_done)
    );

    assign FIFO_RD_EN = rd_en_q;
    assign TXD        = tx_txd;
    assign BUSY       = busy_q;
    assign WORD_CNT   = cnt_q;
    assign ERR        = err_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_fifo_uart_readout.sv
// Bench for fifo_uart_readout: behavioural FIFO driver, UART line decoder with
// an expected-word queue, and directed scenarios for framing, gaps, timeout and wrap.
`timescale 1ns/1ps
module tb_fifo_uart_readout;
    import qn_readout_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int VALID_TO = 4;

    // ---------------- clock / reset ----------------
    logic        clk100     = 1'b0;
    logic        RST_N      = 1'b0;
    logic        FIFO_EMPTY = 1'b1;
    logic [15:0] FIFO_DOUT  = 16'h0000;
    logic        FIFO_VALID = 1'b0;
    logic        FIFO_RD_EN;
    logic        TXD;
    logic        BUSY;
    logic [7:0]  WORD_CNT;
    logic        ERR;
    state_e      DBG_STATE;

    always #5 clk100 = ~clk100;

    fifo_uart_readout #(
        .CLK_DIV  (CLK_DIV),
        .DATA_W   (16),
        .VALID_TO (VALID_TO)
    ) dut (
        .clk100     (clk100),
        .RST_N      (RST_N),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_DOUT  (FIFO_DOUT),
        .FIFO_VALID (FIFO_VALID),
        .FIFO_RD_EN (FIFO_RD_EN),
        .TXD        (TXD),
        .BUSY       (BUSY),
        .WORD_CNT   (WORD_CNT),
        .ERR        (ERR),
        .DBG_STATE  (DBG_STATE)
    );

    // ---------------- bookkeeping ----------------
    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    bit          gapchk_q[$];
    bit          drop_next  = 1'b0;
    bit          inject_req = 1'b0;
    bit          mon_en     = 1'b0;
    bit          pend       = 1'b0;
    logic [15:0] pend_data  = 16'h0000;
    int          pop_cnt    = 0;
    int          rx_cnt     = 0;
    int          cnt_exp    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        chk_cnt++;
        err_cnt++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- FIFO model (drives on negedge) ----------------
    always @(negedge clk100) begin
        FIFO_VALID = 1'b0;
        if (!RST_N) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                FIFO_VALID = 1'b1;
                FIFO_DOUT  = pend_data;
                pend       = 1'b0;
            end else if (inject_req) begin
                FIFO_VALID = 1'b1;
                FIFO_DOUT  = 16'hBEEF;
                inject_req = 1'b0;
            end
            if (FIFO_RD_EN) begin
                pop_cnt++;
                check("pop_nonempty", 32'(fifo_q.size() > 0), 32'd1);
                if (fifo_q.size() > 0) begin
                    pend_data = fifo_q.pop_front();
                    pend      = !drop_next;
                    drop_next = 1'b0;
                end
            end
        end
        FIFO_EMPTY = (fifo_q.size() == 0);
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [15:0] w, input bit gap_chk);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        gapchk_q.push_back(gap_chk);
        cnt_exp++;
    endtask

    task automatic wait_rd_en(input int budget);
        int n = 0;
        while (!FIFO_RD_EN && n < budget) begin
            @(negedge clk100);
            n++;
        end
        if (!FIFO_RD_EN) timeout_fail("wait_rd_en");
    endtask

    task automatic wait_state(input state_e s, input int budget);
        int n = 0;
        while (DBG_STATE != s && n < budget) begin
            @(negedge clk100);
            n++;
        end
        if (DBG_STATE != s) timeout_fail("wait_state");
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && !BUSY && FIFO_EMPTY) && n < budget) begin
            @(negedge clk100);
            n++;
        end
        if (n >= budget) timeout_fail("wait_idle");
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_cnt < target && n < budget) begin
            @(negedge clk100);
            n++;
        end
        if (rx_cnt < target) timeout_fail("wait_rx");
    endtask

    // ---------------- line decoder / scoreboard ----------------
    // Entered on the first negedge of a start bit; returns on the last stop-bit cycle.
    task automatic rx_byte(output logic [7:0] b);
        b = 8'h00;
        repeat (CLK_DIV / 2) @(negedge clk100);
        check("start_bit", 32'(TXD), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CLK_DIV) @(negedge clk100);
            b[i] = TXD;
        end
        repeat (CLK_DIV) @(negedge clk100);
        check("stop_bit", 32'(TXD), 32'd1);
        repeat (CLK_DIV / 2 - 1) @(negedge clk100);
    endtask

    initial begin : monitor
        logic [7:0]  hi_b;
        logic [7:0]  lo_b;
        logic [15:0] exp_w;
        bit          gc;
        int          gap;
        gap = 0;
        forever begin
            @(negedge clk100);
            if (!mon_en || !RST_N) begin
                gap = 0;
            end else if (TXD) begin
                gap++;
            end else begin
                rx_byte(hi_b);
                @(negedge clk100);
                check("hi_lo_gap", 32'(TXD), 32'd0);
                rx_byte(lo_b);
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    err_cnt++;
                    $display("FAIL unexpected_word: got 0x%04h, expected none", {hi_b, lo_b});
                end else begin
                    exp_w = exp_q.pop_front();
                    gc    = gapchk_q.pop_front();
                    check("word", 32'({hi_b, lo_b}), 32'(exp_w));
                    if (gc) check("word_gap", 32'(gap), 32'd2);
                end
                rx_cnt++;
                gap = 0;
            end
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin : main
        int n;
        int base;

        // reset state
        RST_N = 1'b0;
        repeat (3) @(negedge clk100);
        check("rst_txd", 32'(TXD), 32'd1);
        check("rst_rd_en", 32'(FIFO_RD_EN), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_cnt", 32'(WORD_CNT), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_state", 32'(DBG_STATE), 32'(IDLE));
        RST_N  = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk100);

        // single word: pop pulse, latency, frame length
        push_word(16'hA55A, 1'b0);
        wait_rd_en(50);
        @(negedge clk100);
        check("rd_en_pulse", 32'(FIFO_RD_EN), 32'd0);
        check("txd_wait", 32'(TXD), 32'd1);
        @(negedge clk100);
        check("start_latency", 32'(TXD), 32'd0);
        n = 0;
        while (BUSY && n < 200) begin
            n++;
            @(negedge clk100);
        end
        check("frame_len", 32'(n), 32'd80);
        check("cnt_single", 32'(WORD_CNT), 32'(cnt_exp % 256));
        check("busy_single", 32'(BUSY), 32'd0);
        wait_idle(200);

        // three queued words, back-to-back
        push_word(16'h0001, 1'b0);
        push_word(16'h8000, 1'b1);
        push_word(16'hFFFF, 1'b1);
        wait_idle(1000);
        check("cnt_three", 32'(WORD_CNT), 32'(cnt_exp % 256));

        // pop with no VALID -> timeout, then a good word
        drop_next = 1'b1;
        fifo_q.push_back(16'hDEAD);
        wait_rd_en(50);
        @(negedge clk100);
        check("to_state", 32'(DBG_STATE), 32'(WAIT_VALID));
        for (int k = 1; k <= VALID_TO; k++) begin
            if (k > 1) @(negedge clk100);
            check("to_err_low", 32'(ERR), 32'd0);
            check("to_txd", 32'(TXD), 32'd1);
        end
        @(negedge clk100);
        check("to_err_set", 32'(ERR), 32'd1);
        check("to_busy", 32'(BUSY), 32'd0);
        check("to_txd_after", 32'(TXD), 32'd1);
        check("to_cnt", 32'(WORD_CNT), 32'(cnt_exp % 256));
        push_word(16'h1234, 1'b0);
        wait_idle(500);
        check("err_sticky", 32'(ERR), 32'd1);
        check("cnt_after_to", 32'(WORD_CNT), 32'(cnt_exp % 256));

        // stray VALID pulses while sending
        base = pop_cnt;
        push_word(16'h3C96, 1'b0);
        push_word(16'h0F0F, 1'b1);
        wait_state(SEND_HI, 50);
        repeat (10) @(negedge clk100);
        inject_req = 1'b1;
        wait_state(SEND_LO, 100);
        repeat (10) @(negedge clk100);
        inject_req = 1'b1;
        wait_idle(1000);
        check("no_extra_pop", 32'(pop_cnt - base), 32'd2);
        check("cnt_inject", 32'(WORD_CNT), 32'(cnt_exp % 256));

        // reset in the middle of a frame (high byte 0x00 keeps TXD low)
        mon_en = 1'b0;
        fifo_q.push_back(16'h00FF);
        wait_state(SEND_HI, 50);
        repeat (3 * CLK_DIV + 1) @(negedge clk100);
        check("pre_rst_txd", 32'(TXD), 32'd0);
        #1 RST_N = 1'b0;
        #1;
        check("mid_rst_txd", 32'(TXD), 32'd1);
        check("mid_rst_rd_en", 32'(FIFO_RD_EN), 32'd0);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_cnt", 32'(WORD_CNT), 32'd0);
        check("mid_rst_err", 32'(ERR), 32'd0);
        fifo_q.delete();
        cnt_exp = 0;
        repeat (3) @(negedge clk100);
        RST_N = 1'b1;
        repeat (3) @(negedge clk100);
        mon_en = 1'b1;
        repeat (2) @(negedge clk100);

        // 256 words -> count wraps
        base = rx_cnt;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            push_word({iv, ~iv}, (i != 0));
        end
        wait_rx(base + 255, 30000);
        repeat (2) @(negedge clk100);
        check("cnt_255", 32'(WORD_CNT), 32'd255);
        wait_idle(1000);
        check("cnt_wrap", 32'(WORD_CNT), 32'(cnt_exp % 256));
        check("rx_total", 32'(rx_cnt - base), 32'd256);
        check("err_after_rst", 32'(ERR), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
